// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the
// iterative RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            valid_in;
    logic            ready_out;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [RD_W-1:0] rd_in;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [RD_W-1:0] rd_out;

    modport master (
        output valid_in,
        output op,
        output rs1_data,
        output rs2_data,
        output rd_in,
        output flush,
        input  ready_out,
        input  busy,
        input  done,
        input  result,
        input  rd_out
    );

    modport slave (
        input  valid_in,
        input  op,
        input  rs1_data,
        input  rs2_data,
        input  rd_in,
        input  flush,
        output ready_out,
        output busy,
        output done,
        output result,
        output rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 1 bit per cycle
// shift-add multiply and restoring divide on magnitudes.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic          clock,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [RD_W-1:0]   rd_q;
    logic              res_neg;
    logic              rem_neg;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] work_q;
    logic [XLEN-1:0]   result_q;
    logic [RD_W-1:0]   rd_out_q;

    logic              a_sgn;
    logic              b_sgn;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    // Operand decode at accept time
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        unique case (1'b1)
            bus.op == 3'b001: begin
                a_sgn = bus.rs1_data[XLEN-1];
                b_sgn = bus.rs2_data[XLEN-1];
            end
            bus.op == 3'b010: begin
                a_sgn = bus.rs1_data[XLEN-1];
            end
            bus.op == 3'b100,
            bus.op == 3'b110: begin
                a_sgn = bus.rs1_data[XLEN-1];
                b_sgn = bus.rs2_data[XLEN-1];
            end
            default: begin
                a_sgn = 1'b0;
                b_sgn = 1'b0;
            end
        endcase
        a_abs = a_sgn ? -bus.rs1_data : bus.rs1_data;
        b_abs = b_sgn ? -bus.rs2_data : bus.rs2_data;

        div_zero = bus.op[2] && (bus.rs2_data == '0);
        div_ovf  = bus.op[2] && !bus.op[0]
                && (bus.rs1_data == SMIN)
                && (bus.rs2_data == '1);
        if (div_zero)
            special_res = bus.op[1] ? bus.rs1_data : '1;
        else
            special_res = bus.op[1] ? '0 : bus.rs1_data;
    end

    // One iteration: work_q holds {acc, multiplier} or {rem, quo}
    always_comb begin
        mul_sum = {1'b0, work_q[2*XLEN-1:XLEN]}
                + (work_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = work_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (div_diff[XLEN])
                step = {div_shift[XLEN-1:0],
                        work_q[XLEN-2:0], 1'b0};
            else
                step = {div_diff[XLEN-1:0],
                        work_q[XLEN-2:0], 1'b1};
        end else begin
            step = {mul_sum, work_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod_fix = res_neg ? -work_q : work_q;
        quo_fix  = res_neg ? -work_q[XLEN-1:0]
                           : work_q[XLEN-1:0];
        rem_fix  = rem_neg ? -work_q[2*XLEN-1:XLEN]
                           : work_q[2*XLEN-1:XLEN];
        fix_res  = '0;
        unique case (1'b1)
            op_q == 3'b000:
                fix_res = prod_fix[XLEN-1:0];
            !op_q[2] && op_q[1:0] != 2'b00:
                fix_res = prod_fix[2*XLEN-1:XLEN];
            op_q[2] && !op_q[1]:
                fix_res = quo_fix;
            default:
                fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            cnt      <= '0;
            opnd_q   <= '0;
            work_q   <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.valid_in && !bus.flush) begin
                        op_q    <= bus.op;
                        rd_q    <= bus.rd_in;
                        res_neg <= a_sgn ^ b_sgn;
                        rem_neg <= a_sgn;
                        cnt     <= '0;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            rd_out_q <= bus.rd_in;
                            state    <= DONE;
                        end else if (bus.op[2]) begin
                            opnd_q <= b_abs;
                            work_q <= {{XLEN{1'b0}}, a_abs};
                            state  <= RUN;
                        end else begin
                            opnd_q <= a_abs;
                            work_q <= {{XLEN{1'b0}}, b_abs};
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        work_q <= step;
                        cnt    <= cnt + CW'(1);
                        if (cnt == CW'(XLEN-1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        result_q <= fix_res;
                        rd_out_q <= rd_q;
                        state    <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_out = (state == IDLE);
    assign bus.busy      = (state == RUN) || (state == FIX);
    assign bus.done      = (state == DONE);
    assign bus.result    = result_q;
    assign bus.rd_out    = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency,
// special divides, flush and async reset.
module tb_muldiv_unit;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    muldiv_unit_if #(.XLEN(32), .RD_W(5)) bus ();

    muldiv_unit #(.XLEN(32), .RD_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [4:0] rd);
        bus.valid_in = 1'b1;
        bus.op       = op;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd_in    = rd;
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic run_op(input string tag,
                          input logic [2:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [4:0] rd,
                          input logic [31:0] exp,
                          input int lat);
        int cyc;
        int bcnt;
        issue(op, a, b, rd);
        cyc  = 0;
        bcnt = 0;
        while (!bus.done && cyc < 60) begin
            if (bus.busy && !bus.ready_out) bcnt++;
            tick();
            cyc++;
        end
        chk({tag, ".lat"}, cyc, lat);
        chk({tag, ".busy"}, bcnt, lat);
        chk({tag, ".res"}, bus.result, exp);
        chk({tag, ".rd"}, 32'(bus.rd_out), 32'(rd));
        tick();
        chk({tag, ".pulse"}, 32'(bus.done), 32'd0);
        chk({tag, ".rdy"}, 32'(bus.ready_out), 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        total        = 0;
        bad          = 0;
        reset        = 1'b0;
        bus.valid_in = 1'b0;
        bus.flush    = 1'b0;
        bus.op       = 3'b000;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.rd_in    = '0;
        #12;
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.res", bus.result, 32'd0);
        chk("rst.rd", 32'(bus.rd_out), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst.rdy", 32'(bus.ready_out), 32'd1);

        run_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD,
               5'd3, 32'hFFFFFFEB, 33);
        run_op("mulh", 3'b001, 32'h80000000, 32'h80000000,
               5'd4, 32'h40000000, 33);
        run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF,
               5'd5, 32'hFFFFFFFE, 33);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF,
               5'd6, 32'hFFFFFFFF, 33);
        run_op("div", 3'b100, 32'hFFFFFFF9, 32'd2,
               5'd7, 32'hFFFFFFFD, 33);
        run_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2,
               5'd8, 32'hFFFFFFFF, 33);
        run_op("divu", 3'b101, 32'd100, 32'd7,
               5'd9, 32'd14, 33);
        run_op("remu", 3'b111, 32'd100, 32'd7,
               5'd10, 32'd2, 33);
        run_op("div0", 3'b100, 32'd5, 32'd0,
               5'd11, 32'hFFFFFFFF, 0);
        run_op("remu0", 3'b111, 32'd5, 32'd0,
               5'd12, 32'd5, 0);
        run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF,
               5'd13, 32'h80000000, 0);
        run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF,
               5'd14, 32'd0, 0);

        // Flush a DIVU at iteration 10
        held = bus.result;
        issue(3'b101, 32'd100, 32'd7, 5'd15);
        for (int i = 0; i < 9; i++) tick();
        chk("fl.busy0", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        tick();
        chk("fl.busy", 32'(bus.busy), 32'd0);
        chk("fl.rdy", 32'(bus.ready_out), 32'd1);
        chk("fl.done", 32'(bus.done), 32'd0);
        chk("fl.res", bus.result, held);
        // Request together with flush in IDLE is dropped
        bus.valid_in = 1'b1;
        bus.op       = 3'b000;
        bus.rs1_data = 32'd9;
        bus.rs2_data = 32'd9;
        bus.rd_in    = 5'd16;
        tick();
        bus.valid_in = 1'b0;
        bus.flush    = 1'b0;
        chk("fl.noacc", 32'(bus.ready_out), 32'd1);
        chk("fl.nobusy", 32'(bus.busy), 32'd0);
        chk("fl.res2", bus.result, held);
        run_op("mul34", 3'b000, 32'd3, 32'd4,
               5'd17, 32'd12, 33);

        // Async reset between edges in the middle of RUN
        issue(3'b100, 32'd1000, 32'd3, 5'd18);
        for (int i = 0; i < 5; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        chk("ar.busy", 32'(bus.busy), 32'd0);
        chk("ar.done", 32'(bus.done), 32'd0);
        chk("ar.res", bus.result, 32'd0);
        chk("ar.rd", 32'(bus.rd_out), 32'd0);
        reset = 1'b1;
        tick();
        chk("ar.rdy", 32'(bus.ready_out), 32'd1);
        run_op("ardiv", 3'b100, 32'hFFFFFFF9, 32'd2,
               5'd19, 32'hFFFFFFFD, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide execution unit for the RV32M extension. It sits in the EX stage beside the ALU.
- Takes operands after the forwarding muxes, along with funct3 and the destination register.
- Asserts busy so the hazard detection logic holds PC, IF/ID and ID/EX.
- Returns one result with a single-cycle done pulse, which feeds EX/MEM.
- Supports EX flush on branch redirect.

Parameters:
- XLEN, 32, operand/result width; must be at least 8 and even.
- RD_W, 5, destination-register tag width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  request valid
- ready_out  out  1  unit can accept a request this cycle
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  in  XLEN  operand A (dividend / multiplicand)
- rs2_data  in  XLEN  operand B (divisor / multiplier)
- rd_in  in  RD_W  destination tag
- flush  in  1  synchronous kill of any in-flight op
- busy  out  1  op in flight; stall request to hazard logic
- done  out  1  result valid, one-cycle pulse
- result  out  XLEN  result, held until next done
- rd_out  out  RD_W  tag of result, held with result

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, result=0, rd_out=0; internal accumulators and counter cleared. ready_out=1 once reset deasserts.
- States: IDLE, RUN, FIX, DONE.
- ready_out = (state==IDLE). busy = (state==RUN or FIX). done = (state==DONE).
- Accept: the edge with valid_in=1, ready_out=1 and flush=0.
  - At accept, latch op, rd_in, |rs1| and |rs2| (absolute value for signed operands only), and the result-sign flags.
  - MULH: both operands signed. MULHSU: rs1 signed. DIV/REM: both signed. All others unsigned.
- Special divide cases skip RUN/FIX: accept→DONE directly, so done is high the cycle after accept (latency 1).
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow (DIV/REM with rs1=100..0, rs2=all ones): DIV → rs1; REM → 0.
- Normal path: accept→RUN with counter=0. In RUN, one iteration per edge; after the XLEN-th iteration (counter==XLEN-1) → FIX.
  - Multiply: shift-add into a 2·XLEN product, 1 bit/cycle.
  - Divide: restoring divide, 1 quotient bit/cycle, with an XLEN+1-bit partial remainder.
- FIX → DONE: apply sign correction by two's complement.
  - Product negative iff signs differ (MULHSU: iff rs1 negative).
  - Quotient negative iff signs differ.
  - Remainder takes the sign of the dividend.
  - Select the low half (MUL) or high half (MULH*), quotient or remainder. result and rd_out are registered on this edge.
- DONE → IDLE unconditionally on the next edge. Total normal latency: done high in cycle XLEN+2 counting the accept edge as edge 0 (XLEN=32: done visible after edge 33).
- Zero operands are not special-cased for multiply; they take full latency.
- flush=1 at an edge in RUN or FIX → IDLE. No done is produced; result and rd_out are unchanged.
- flush in IDLE with valid_in=1: the request is not accepted.
- flush in DONE: done still completes (result is already committed); the state returns to IDLE.
- Back-to-back ops: a new op is accepted in IDLE at the earliest, i.e. the edge after DONE. Minimum issue interval is XLEN+3 cycles.
- valid_in while not ready is ignored; the requester must hold the request. Pipeline stall via busy ensures it.
- Async reset mid-op: outputs clear immediately (not at the next edge). The op is lost.
- All arithmetic is modulo 2^XLEN. Results are bit-exact to the RISC-V M specification.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3) → result 0xFFFFFFEB, rd_out=rd_in. done high exactly one cycle, after edge 33 from accept. busy high through edges 1..33, ready_out low throughout.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7)/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, with done the cycle after accept. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, each in 1 cycle.
- DIVU 100/7 accepted, then flush asserted at iteration 10:
  - busy drops the next cycle; no done pulse; result keeps its previous value.
  - A MUL 3×4 issued next cycle → 12 with full latency.
  - valid_in together with flush in IDLE is not accepted.
- reset pulled low between edges mid-RUN → busy, done, result and rd_out are 0 before the next edge. After release, ready_out=1 and a fresh DIV −7/2 returns 0xFFFFFFFD.
